// File: rtl/countdown_regs_if.sv
// Bundles the preset/clear, control and status signals of the countdown register stage.
// The master drives preset/clear/start/en; the slave (countdown_regs) returns value and status.
interface countdown_regs_if;
    logic [1:0] psDS;
    logic [1:0] psUS;
    logic [1:0] clDS;
    logic [1:0] clUS;
    logic       start;
    logic       en;
    logic [1:0] cnt_DS;
    logic [1:0] cnt_US;
    logic       running;
    logic       done;
    logic       zero_pulse;

    modport master (
        output psDS, psUS, clDS, clUS, start, en,
        input  cnt_DS, cnt_US, running, done, zero_pulse
    );

    modport slave (
        input  psDS, psUS, clDS, clUS, start, en,
        output cnt_DS, cnt_US, running, done, zero_pulse
    );
endinterface

// File: rtl/countdown_regs.sv
// Countdown register stage: captures preset/clear loads into {DS,US}, then counts down per tick.
// Optional macro AUTO_RELOAD_EN: a zero tick reloads the shadow value and keeps running.
module countdown_regs #(
    parameter int unsigned DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_regs_if.slave  bus
);
    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PresTop = PW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoaded, StRunning, StDone} state_e;

    state_e        r_state, w_state_d;
    logic [3:0]    r_value, w_value_d;
    logic [3:0]    r_shadow, w_shadow_d;
    logic [PW-1:0] r_presc, w_presc_d;
    logic          r_zero_pulse, w_zero_pulse_d;

    logic [3:0]    w_ps, w_cl, w_new_value;
    logic          w_load, w_tick, w_zero_tick, w_auto;

    assign w_ps        = {bus.psDS, bus.psUS};
    assign w_cl        = {bus.clDS, bus.clUS};
    assign w_load      = |{w_ps, w_cl};
    // Preset beats clear on the same bit; untouched bits hold.
    assign w_new_value = w_ps | (~w_cl & r_value);
    assign w_tick      = (r_state == StRunning) && bus.en && (r_presc == PresTop);
    assign w_zero_tick = w_tick && (r_value == 4'd1);

`ifdef AUTO_RELOAD_EN
    assign w_auto = w_zero_tick && (r_shadow != 4'd0);
`else
    assign w_auto = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_value      <= 4'd0;
            r_shadow     <= 4'd0;
            r_presc      <= '0;
            r_zero_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_value      <= w_value_d;
            r_shadow     <= w_shadow_d;
            r_presc      <= w_presc_d;
            r_zero_pulse <= w_zero_pulse_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_load) begin
            w_state_d = StLoaded;
        end else begin
            case (r_state)
                StIdle:    w_state_d = StIdle;
                StLoaded:  if (bus.start) w_state_d = (r_value == 4'd0) ? StDone : StRunning;
                StRunning: if (w_zero_tick && !w_auto) w_state_d = StDone;
                StDone:    if (bus.start && (r_shadow != 4'd0)) w_state_d = StRunning;
                default:   w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_value_d      = r_value;
        w_shadow_d     = r_shadow;
        w_presc_d      = r_presc;
        w_zero_pulse_d = 1'b0;
        if (w_load) begin
            w_value_d  = w_new_value;
            w_shadow_d = w_new_value;
            w_presc_d  = '0;
        end else begin
            case (r_state)
                StLoaded: begin
                    if (bus.start) w_presc_d = '0;
                end
                StRunning: begin
                    if (bus.en) begin
                        if (w_tick) begin
                            w_presc_d = '0;
                            if (w_zero_tick) begin
                                w_zero_pulse_d = 1'b1;
                                w_value_d      = w_auto ? r_shadow : 4'd0;
                            end else if (r_value != 4'd0) begin
                                w_value_d = r_value - 4'd1;
                            end
                        end else begin
                            w_presc_d = r_presc + PW'(1);
                        end
                    end
                end
                StDone: begin
                    w_value_d = 4'd0;
                    if (bus.start && (r_shadow != 4'd0)) begin
                        w_value_d = r_shadow;
                        w_presc_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cnt_DS     = r_value[3:2];
    assign bus.cnt_US     = r_value[1:0];
    assign bus.running    = (r_state == StRunning);
    assign bus.done       = (r_state == StDone);
    assign bus.zero_pulse = r_zero_pulse;
endmodule
